// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from CLOCK_50 with a divide-by-2 pixel enable.
// Sync/blank are delayed by RENDER_LATENCY cycles to align with the renderer's colour register.
module vga_timing_gen #(
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BACK         = 48,
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FRONT        = 16,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BACK         = 33,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FRONT        = 10,
    parameter int unsigned RENDER_LATENCY = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic [9:0]  VGA_X,
    output logic [9:0]  VGA_Y,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        pixel_active,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic        pix_en_q;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        line_tick_q, line_tick_d;
    logic        frame_tick_q, frame_tick_d;

    logic hs_raw, vs_raw, blank_raw;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;
        line_tick_d   = 1'b0;
        frame_tick_d  = 1'b0;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d         = '0;
                line_tick_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_count_d = frame_count_q + 16'd1;
                    frame_tick_d  = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            line_tick_q   <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            pix_en_q      <= ~pix_en_q;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            line_tick_q   <= line_tick_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign pixel_active = (x_q >= H_ACT_START) && (x_q < H_ACT_END) &&
                          (y_q >= V_ACT_START) && (y_q < V_ACT_END);

    assign hs_raw    = ~(x_q < H_SYNC_END);
    assign vs_raw    = ~(y_q < V_SYNC_END);
    assign blank_raw = pixel_active;

    generate
        if (RENDER_LATENCY == 0) begin : g_no_delay
            assign VGA_HS      = hs_raw;
            assign VGA_VS      = vs_raw;
            assign VGA_BLANK_N = blank_raw;
        end else begin : g_delay
            logic [RENDER_LATENCY-1:0] hs_pipe_q;
            logic [RENDER_LATENCY-1:0] vs_pipe_q;
            logic [RENDER_LATENCY-1:0] blank_pipe_q;

            // Stage 0 takes the decode; each later stage shifts from the one before.
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    hs_pipe_q    <= '1;
                    vs_pipe_q    <= '1;
                    blank_pipe_q <= '0;
                end else begin
                    hs_pipe_q[0]    <= hs_raw;
                    vs_pipe_q[0]    <= vs_raw;
                    blank_pipe_q[0] <= blank_raw;
                    for (int unsigned i = 1; i < RENDER_LATENCY; i++) begin
                        hs_pipe_q[i]    <= hs_pipe_q[i-1];
                        vs_pipe_q[i]    <= vs_pipe_q[i-1];
                        blank_pipe_q[i] <= blank_pipe_q[i-1];
                    end
                end
            end

            assign VGA_HS      = hs_pipe_q[RENDER_LATENCY-1];
            assign VGA_VS      = vs_pipe_q[RENDER_LATENCY-1];
            assign VGA_BLANK_N = blank_pipe_q[RENDER_LATENCY-1];
        end
    endgenerate

    assign VGA_X       = x_q;
    assign VGA_Y       = y_q;
    assign VGA_CLK     = pix_en_q;
    assign VGA_SYNC_N  = 1'b0;
    assign line_tick   = line_tick_q;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from CLOCK_50 using a divide-by-2 pixel enable (25 MHz).
- Drives the raw pixel coordinates VGA_X/VGA_Y consumed by the downstream pixel renderer.
- Drives the sync, blank and clock pins of the VGA DAC.
- Provides line_tick and frame_tick strobes so game logic can update object positions once per frame.
- Sync/blank outputs are delayed to line up with the renderer's 1-cycle registered colour output.

Parameters:
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- RENDER_LATENCY, 1, CLOCK_50 cycles of delay applied to VGA_HS/VGA_VS/VGA_BLANK_N (range 0..4)

Ports:
- CLOCK_50  input  1  50 MHz system clock
- reset  input  1  asynchronous, active-high reset
- VGA_X  output  10  raw horizontal counter 0..799; sync region starts at 0, active region is 144..783
- VGA_Y  output  10  raw vertical counter 0..524; active region is 35..514
- VGA_CLK  output  1  25 MHz pixel clock to the DAC
- VGA_HS  output  1  horizontal sync, active low
- VGA_VS  output  1  vertical sync, active low
- VGA_BLANK_N  output  1  high only inside the active region
- VGA_SYNC_N  output  1  tied to 0
- pixel_active  output  1  undelayed active-region flag for the current VGA_X/VGA_Y
- line_tick  output  1  one-CLOCK_50 pulse when VGA_X wraps
- frame_tick  output  1  one-CLOCK_50 pulse when VGA_X and VGA_Y both wrap
- frame_count  output  16  free-running frame counter

Behaviour:
- Derived totals: H_TOTAL = 800, V_TOTAL = 525 with the defaults.
- Region order per line: sync, back porch, active, front porch. Same order per frame for lines.
- Reset values (asynchronous):
  - pix_en = 0, VGA_X = 0, VGA_Y = 0, frame_count = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, pixel_active = 0
  - line_tick = 0, frame_tick = 0, VGA_CLK = 0
  - all delay-pipeline stages load HS = 1, VS = 1, BLANK_N = 0
- pix_en toggles on every CLOCK_50 edge. VGA_CLK = pix_en (registered, 50% duty).
- Counter advance: on an edge where pix_en == 1 (pre-toggle value):
  - VGA_X increments.
  - At VGA_X == H_TOTAL-1, VGA_X goes to 0 and VGA_Y increments.
  - At VGA_Y == V_TOTAL-1 on that same edge, VGA_Y goes to 0 and frame_count increments (16-bit wrap 65535 -> 0).
- First edge after reset release: no advance, pix_en becomes 1. The second edge moves VGA_X to 1.
- Counter values are held for exactly 2 CLOCK_50 cycles.
- line_tick is asserted for exactly 1 cycle, in the cycle where the new VGA_X == 0.
- frame_tick is asserted for exactly 1 cycle, in the cycle where the new VGA_X == 0 and VGA_Y == 0. It coincides with line_tick and with the frame_count update.
- pixel_active = (H_SYNC+H_BACK <= VGA_X < H_SYNC+H_BACK+H_ACTIVE) and (V_SYNC+V_BACK <= VGA_Y < V_SYNC+V_BACK+V_ACTIVE). Combinational from the counters.
- Sync decode:
  - hs_raw = 0 when VGA_X < H_SYNC
  - vs_raw = 0 when VGA_Y < V_SYNC
  - blank_raw = pixel_active
- Delay pipeline: each raw value passes through a RENDER_LATENCY-deep CLOCK_50 shift register.
  - RENDER_LATENCY = 0 drives the pins directly from the decode.
  - Default 1: VGA_BLANK_N rises exactly 1 cycle after VGA_X becomes 144, matching the renderer's colour register.
- VGA_X/VGA_Y are never delayed.
- Reset mid-frame: everything returns to reset values immediately, with no partial frame_tick. Timing restarts from (0,0) after release.
- Widths: counters are 10 bits. No value beyond H_TOTAL-1 / V_TOTAL-1 is ever produced.

Test Plan:
- Reset then release -> VGA_X = 0 for 2 cycles, then 1, 2, … each held for 2 cycles. VGA_CLK toggles every cycle. VGA_SYNC_N = 0 always.
- Run 1 line -> VGA_HS low for exactly 192 CLOCK_50 cycles starting 1 cycle after VGA_X = 0. line_tick period = 1600 cycles. VGA_Y increments at the VGA_X 799 -> 0 transition.
- Run 2 frames -> frame_tick period = 840000 cycles. VGA_VS low for 3200 cycles per frame. frame_count goes 0 -> 1 -> 2. frame_tick coincides with line_tick.
- Active window -> pixel_active high only for VGA_X 144..783 and VGA_Y 35..514 (307200 pixels/frame). VGA_BLANK_N is the same waveform delayed exactly 1 cycle.
- Reset at VGA_X = 400, VGA_Y = 200 -> all outputs go to reset values in the same cycle. After release, the first frame_tick arrives exactly 840000 cycles after the first count.
- Force frame_count to 65535 (run long or preload) -> the next frame_tick wraps frame_count to 0.
